modexp_ctrl: RTL and testbench
==============================

MODEXP_CTRL -- requirements
Module: modexp_ctrl

Interface
REQ-001 Parameter: SIZE, default 64, operand width in bits for base, exponent, modulus and result.
REQ-002 clk  input  1  single clock, all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_base_tdata / in_exp_tdata / in_mod_tdata  input  SIZE each  job operands; in_tvalid input 1, in_tready output 1 (one shared handshake).
REQ-005 res_tdata  output  SIZE  base^exp mod mod; res_tvalid output 1; res_tready input 1.
REQ-006 md_dividen_tdata  output  2*SIZE  product to external modulo unit; md_dividen_tvalid output 1; md_dividen_tready input 1.
REQ-007 md_divisor_tdata  output  SIZE  modulus to external modulo unit; md_divisor_tvalid output 1; md_divisor_tready input 1.
REQ-008 md_rem_tdata  input  SIZE  remainder from modulo unit; md_rem_tvalid input 1; md_rem_tready output 1.
REQ-009 busy  output  1  high from job acceptance until result handshake completes.

Function
REQ-010 Algorithm: right-to-left square-and-multiply; acc=1, b=base mod m; per iteration: if e[0], acc=acc*b mod m; b=b*b mod m; e=e>>1.
REQ-011 States: IDLE, RED_BASE, MUL, SEND, WAIT_REM, NEXT, DONE.
REQ-012 IDLE: in_tready=1; on in_tvalid latch operands, go RED_BASE.
REQ-013 Latched modulus < 2: skip all modulo transactions, result 0, go DONE next cycle.
REQ-014 RED_BASE: dividend = base zero-extended to 2*SIZE, go SEND; remainder loads b.
REQ-015 MUL: internal shift-add multiplier, exactly SIZE cycles, full 2*SIZE-bit unsigned product, no truncation; then SEND.
REQ-016 SEND: assert md_dividen_tvalid and md_divisor_tvalid together; each valid holds, with stable data, until its own ready seen; leave SEND only after both accepted (either order or same cycle).
REQ-017 WAIT_REM: md_rem_tready=1 only in this state; on md_rem_tvalid capture remainder into acc or b per current operation, go NEXT (or MUL for pending square).
REQ-018 Per iteration ordering: multiply (if e[0]=1) precedes square; both use b value from iteration start.
REQ-019 NEXT: shift e, increment iteration counter; after SIZE iterations go DONE.
REQ-020 DONE: res_tvalid=1, res_tdata=acc held stable until res_tready; then IDLE, busy=0.
REQ-021 md_rem_tvalid outside WAIT_REM: ignored, not captured.
REQ-022 in_tvalid while busy: ignored; in_tready=0.

Reset
REQ-023 rst forces IDLE from any state including mid-transaction, same cycle edge.
REQ-024 Reset values: in_tready=1 after reset release, res_tvalid=0, res_tdata=0, md_* tvalid=0, md_rem_tready=0, busy=0, md_* tdata=0.
REQ-025 Reset mid-SEND drops valids without completing handshake; no recovery of in-flight job.

Configuration
REQ-026 Macro MODEXP_EARLY_EXIT_EN.
REQ-027 Defined: in NEXT, if shifted exponent is 0, go DONE immediately; exponent 0 yields result 1 after only base reduction.
REQ-028 Undefined: always exactly SIZE iterations, multiply step performed and result discarded when e[0]=0 (constant-time; acc unchanged).
REQ-029 Results identical in both configurations; only cycle count differs.

Verification
REQ-030 SIZE=64, base=3, exp=5, mod=7, modulo model with 1-cycle ready -> res_tdata=5; with MODEXP_EARLY_EXIT_EN, exactly 3 iterations.
REQ-031 base=2, exp=10, mod=1000 -> res_tdata=24; base=1234, exp=0, mod=13 -> res_tdata=1.
REQ-032 mod=1 and mod=0, any base/exp -> res_tdata=0, no md_dividen_tvalid ever asserted.
REQ-033 md_divisor_tready delayed 5 cycles past md_dividen_tready, random md_rem_tvalid stalls -> data stable while valid, correct result 5 for REQ-030 operands.
REQ-034 res_tready held low 10 cycles -> res_tvalid/res_tdata stable, in_tready=0 throughout; second job accepted only after handshake.
REQ-035 rst pulsed during WAIT_REM -> all outputs at reset values next cycle; fresh job 3^5 mod 7 then returns 5.

Source files
------------

// File: rtl/modexp_ctrl.sv
// modexp_ctrl: modular exponentiation controller, right-to-left square-and-multiply.
// Products come from an internal shift-add multiplier; reductions go to an external
// modulo unit over valid/ready channels. Optional macro MODEXP_EARLY_EXIT_EN stops
// iterating once the remaining exponent is zero and skips multiplies for zero bits.
module modexp_ctrl #(
  parameter int unsigned SIZE = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SIZE-1:0]   in_base_tdata,
  input  logic [SIZE-1:0]   in_exp_tdata,
  input  logic [SIZE-1:0]   in_mod_tdata,
  input  logic              in_tvalid,
  output logic              in_tready,
  output logic [SIZE-1:0]   res_tdata,
  output logic              res_tvalid,
  input  logic              res_tready,
  output logic [2*SIZE-1:0] md_dividen_tdata,
  output logic              md_dividen_tvalid,
  input  logic              md_dividen_tready,
  output logic [SIZE-1:0]   md_divisor_tdata,
  output logic              md_divisor_tvalid,
  input  logic              md_divisor_tready,
  input  logic [SIZE-1:0]   md_rem_tdata,
  input  logic              md_rem_tvalid,
  output logic              md_rem_tready,
  output logic              busy
);

  localparam int unsigned PW = 2 * SIZE;
  localparam int unsigned CW = (SIZE > 1) ? $clog2(SIZE) : 1;
`ifdef MODEXP_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, RED_BASE, MUL, SEND, WAIT_REM, NEXT, DONE} state_t;
  typedef enum logic [1:0] {OP_RED, OP_MUL, OP_SQR} op_t;

  state_t          state_q, state_nxt;
  op_t             op_q, op_new;
  logic [SIZE-1:0] acc_q, b_q, e_q, m_q, mplier_q;
  logic [SIZE-1:0] acc_new, b_new, mul_x, e_shift;
  logic [PW-1:0]   prod_q, mcand_q;
  logic [CW-1:0]   mcnt_q, iter_q;
  logic            accept, rem_fire, dvd_ok, dvs_ok, mod_small, mul_load, e_start0;
  logic            in_tready_d, busy_d, res_tvalid_d, md_rem_tready_d, dvd_vld_d, dvs_vld_d;

  assign accept    = in_tready & in_tvalid;
  assign rem_fire  = md_rem_tready & md_rem_tvalid;
  assign dvd_ok    = ~md_dividen_tvalid | md_dividen_tready;
  assign dvs_ok    = ~md_divisor_tvalid | md_divisor_tready;
  assign mod_small = (m_q < SIZE'(2));
  assign e_shift   = e_q >> 1;
  assign mul_load  = (state_nxt == MUL) && (state_q != MUL);

  assign res_tdata        = acc_q;
  assign md_dividen_tdata = prod_q;
  assign md_divisor_tdata = m_q;

  // State register and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      in_tready         <= 1'b1;
      busy              <= 1'b0;
      res_tvalid        <= 1'b0;
      md_rem_tready     <= 1'b0;
      md_dividen_tvalid <= 1'b0;
      md_divisor_tvalid <= 1'b0;
    end else begin
      state_q           <= state_nxt;
      in_tready         <= in_tready_d;
      busy              <= busy_d;
      res_tvalid        <= res_tvalid_d;
      md_rem_tready     <= md_rem_tready_d;
      md_dividen_tvalid <= dvd_vld_d;
      md_divisor_tvalid <= dvs_vld_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:     if (accept) state_nxt = RED_BASE;
      RED_BASE: state_nxt = mod_small ? DONE : SEND;
      MUL:      if (mcnt_q == CW'(SIZE - 1)) state_nxt = SEND;
      SEND:     if (dvd_ok && dvs_ok) state_nxt = WAIT_REM;
      WAIT_REM: begin
        if (rem_fire) begin
          if (op_q == OP_SQR)                                     state_nxt = NEXT;
          else if (op_q == OP_RED && EARLY_EXIT && e_q == '0)     state_nxt = DONE;
          else                                                    state_nxt = MUL;
        end
      end
      NEXT: begin
        if (iter_q == CW'(SIZE - 1) || (EARLY_EXIT && e_shift == '0)) state_nxt = DONE;
        else                                                          state_nxt = MUL;
      end
      DONE:     if (res_tready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs; each md valid drops on its own ready
  always_comb begin
    in_tready_d     = (state_nxt == IDLE);
    busy_d          = (state_nxt != IDLE);
    res_tvalid_d    = (state_nxt == DONE);
    md_rem_tready_d = (state_nxt == WAIT_REM);
    dvd_vld_d       = md_dividen_tvalid & ~md_dividen_tready;
    dvs_vld_d       = md_divisor_tvalid & ~md_divisor_tready;
    if (state_nxt == SEND && state_q != SEND) begin
      dvd_vld_d = 1'b1;
      dvs_vld_d = 1'b1;
    end
  end

  // Values after this cycle's remainder capture, and the next multiplier operation
  always_comb begin
    acc_new = acc_q;
    b_new   = b_q;
    if (rem_fire) begin
      if (op_q == OP_MUL) begin
        if (e_q[0]) acc_new = md_rem_tdata;
      end else begin
        b_new = md_rem_tdata;
      end
    end
    e_start0 = (state_q == NEXT) ? e_shift[0] : e_q[0];
    if (state_q == WAIT_REM && op_q == OP_MUL) op_new = OP_SQR;
    else if (EARLY_EXIT && !e_start0)          op_new = OP_SQR;
    else                                       op_new = OP_MUL;
    mul_x = (op_new == OP_MUL) ? acc_new : b_new;
  end

  // Operand registers, exponent walk and shift-add multiplier
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      b_q      <= '0;
      e_q      <= '0;
      m_q      <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      mcnt_q   <= '0;
      iter_q   <= '0;
      op_q     <= OP_RED;
    end else begin
      if (accept) begin
        b_q    <= in_base_tdata;
        e_q    <= in_exp_tdata;
        m_q    <= in_mod_tdata;
        acc_q  <= SIZE'(1);
        iter_q <= '0;
      end
      if (state_q == RED_BASE) begin
        if (mod_small) begin
          acc_q <= '0;
        end else begin
          prod_q <= PW'(b_q);
          op_q   <= OP_RED;
        end
      end
      if (rem_fire) begin
        acc_q <= acc_new;
        b_q   <= b_new;
      end
      if (state_q == NEXT) begin
        e_q    <= e_shift;
        iter_q <= iter_q + CW'(1);
      end
      if (mul_load) begin
        op_q     <= op_new;
        prod_q   <= '0;
        mcand_q  <= PW'(mul_x);
        mplier_q <= b_new;
        mcnt_q   <= '0;
      end
      if (state_q == MUL) begin
        if (mplier_q[0]) prod_q <= prod_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        mcnt_q   <= mcnt_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_modexp_ctrl.sv
// tb_modexp_ctrl: directed bench for modexp_ctrl with a behavioural modulo unit.
`timescale 1ns/1ps
module tb_modexp_ctrl;

  localparam int unsigned SIZE = 64;
  localparam int unsigned PW   = 2 * SIZE;
  localparam int          BOUND = 15000;
`ifdef MODEXP_EARLY_EXIT_EN
  localparam int N_35 = 6, N_210 = 7, N_EXP0 = 1;
`else
  localparam int N_35 = 129, N_210 = 129, N_EXP0 = 129;
`endif

  logic            clk;
  logic            rst;
  logic [SIZE-1:0] in_base_tdata, in_exp_tdata, in_mod_tdata;
  logic            in_tvalid, in_tready;
  logic [SIZE-1:0] res_tdata;
  logic            res_tvalid, res_tready;
  logic [PW-1:0]   md_dividen_tdata;
  logic            md_dividen_tvalid, md_dividen_tready;
  logic [SIZE-1:0] md_divisor_tdata;
  logic            md_divisor_tvalid, md_divisor_tready;
  logic [SIZE-1:0] md_rem_tdata;
  logic            md_rem_tvalid, md_rem_tready;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_dvd    = 0;
  bit dvd_seen = 0;
  bit stall_mode = 0;

  modexp_ctrl #(.SIZE(SIZE)) dut (
    .clk(clk), .rst(rst),
    .in_base_tdata(in_base_tdata), .in_exp_tdata(in_exp_tdata), .in_mod_tdata(in_mod_tdata),
    .in_tvalid(in_tvalid), .in_tready(in_tready),
    .res_tdata(res_tdata), .res_tvalid(res_tvalid), .res_tready(res_tready),
    .md_dividen_tdata(md_dividen_tdata), .md_dividen_tvalid(md_dividen_tvalid),
    .md_dividen_tready(md_dividen_tready),
    .md_divisor_tdata(md_divisor_tdata), .md_divisor_tvalid(md_divisor_tvalid),
    .md_divisor_tready(md_divisor_tready),
    .md_rem_tdata(md_rem_tdata), .md_rem_tvalid(md_rem_tvalid), .md_rem_tready(md_rem_tready),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Modulo unit model: samples just after each rising edge, drives readys and the remainder
  initial begin : mod_model
    bit              s_dvd_v, s_dvs_v, s_rem_rdy, have_dvd, have_dvs, rem_pend;
    logic [PW-1:0]   s_dvd_d, dvd_val;
    logic [SIZE-1:0] s_dvs_d, dvs_val, rem_val;
    int              dvs_cnt;
    s_dvd_v = 0; s_dvs_v = 0; s_rem_rdy = 0; have_dvd = 0; have_dvs = 0; rem_pend = 0;
    s_dvd_d = '0; s_dvs_d = '0; dvd_val = '0; dvs_val = '0; rem_val = '0; dvs_cnt = 0;
    md_dividen_tready = 1'b0; md_divisor_tready = 1'b0;
    md_rem_tvalid = 1'b0; md_rem_tdata = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        s_dvd_v = 0; s_dvs_v = 0; s_rem_rdy = 0; have_dvd = 0; have_dvs = 0; rem_pend = 0;
        md_dividen_tready = 1'b0; md_divisor_tready = 1'b0; md_rem_tvalid = 1'b0;
      end else begin
        if (s_dvd_v && md_dividen_tready) begin
          have_dvd = 1; dvd_val = s_dvd_d; n_dvd++; dvs_cnt = 6;
          check_eq("dvd_drop", md_dividen_tvalid, 1'b0);
        end else if (s_dvd_v) begin
          check_eq("dvd_hold_v", md_dividen_tvalid, 1'b1);
          check_eq("dvd_hold_d", md_dividen_tdata, s_dvd_d);
        end
        if (s_dvs_v && md_divisor_tready) begin
          have_dvs = 1; dvs_val = s_dvs_d;
          check_eq("dvs_drop", md_divisor_tvalid, 1'b0);
        end else if (s_dvs_v) begin
          check_eq("dvs_hold_v", md_divisor_tvalid, 1'b1);
          check_eq("dvs_hold_d", PW'(md_divisor_tdata), PW'(s_dvs_d));
        end
        if (s_rem_rdy && md_rem_tvalid) rem_pend = 0;
        if (have_dvd && have_dvs && !rem_pend) begin
          rem_val  = SIZE'(dvd_val % PW'(dvs_val));
          rem_pend = 1; have_dvd = 0; have_dvs = 0;
        end
        md_dividen_tready = 1'b1;
        if (stall_mode) begin
          if (have_dvd && dvs_cnt > 0) dvs_cnt--;
          md_divisor_tready = have_dvd && (dvs_cnt == 0);
        end else begin
          md_divisor_tready = 1'b1;
        end
        if (!rem_pend)          md_rem_tvalid = 1'b0;
        else if (!md_rem_tvalid) md_rem_tvalid = stall_mode ? ($urandom_range(0, 2) == 0) : 1'b1;
        md_rem_tdata = rem_val;
        s_dvd_v = md_dividen_tvalid; s_dvd_d = md_dividen_tdata;
        s_dvs_v = md_divisor_tvalid; s_dvs_d = md_divisor_tdata;
        s_rem_rdy = md_rem_tready;
        if (md_dividen_tvalid) dvd_seen = 1;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_in_tready"},  in_tready, 1'b1);
    check_eq({tag, "_res_tvalid"}, res_tvalid, 1'b0);
    check_eq({tag, "_res_tdata"},  PW'(res_tdata), '0);
    check_eq({tag, "_dvd_tvalid"}, md_dividen_tvalid, 1'b0);
    check_eq({tag, "_dvs_tvalid"}, md_divisor_tvalid, 1'b0);
    check_eq({tag, "_rem_tready"}, md_rem_tready, 1'b0);
    check_eq({tag, "_busy"},       busy, 1'b0);
    check_eq({tag, "_dvd_tdata"},  md_dividen_tdata, '0);
    check_eq({tag, "_dvs_tdata"},  PW'(md_divisor_tdata), '0);
  endtask

  // Present a job at a falling edge and hold it until the accepting rising edge
  task automatic start_job(input string tag, input logic [SIZE-1:0] b, e, m);
    int k;
    in_base_tdata = b; in_exp_tdata = e; in_mod_tdata = m; in_tvalid = 1'b1;
    k = 0;
    while (!in_tready && k < 50) begin @(negedge clk); k++; end
    check_eq({tag, "_accept"}, in_tready, 1'b1);
    @(negedge clk);
    in_tvalid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [SIZE-1:0] exp_res);
    int k;
    k = 0;
    while (!res_tvalid && k < BOUND) begin @(negedge clk); k++; end
    check_eq({tag, "_valid"}, res_tvalid, 1'b1);
    check_eq({tag, "_res"},   PW'(res_tdata), PW'(exp_res));
    check_eq({tag, "_busy"},  busy, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_tvalid = 1'b0; res_tready = 1'b1;
    in_base_tdata = '0; in_exp_tdata = '0; in_mod_tdata = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst = 1'b0;
    @(negedge clk);
    check_eq("rel_in_tready", in_tready, 1'b1);

    // 3^5 mod 7
    n_dvd = 0;
    start_job("j35", 64'd3, 64'd5, 64'd7);
    wait_result("j35", 64'd5);
    check_eq("j35_ndvd", PW'(n_dvd), PW'(N_35));
    check_eq("j35_idle_tready", in_tready, 1'b1);
    check_eq("j35_idle_busy", busy, 1'b0);
    check_eq("j35_idle_rvalid", res_tvalid, 1'b0);

    // 2^10 mod 1000
    n_dvd = 0;
    start_job("j210", 64'd2, 64'd10, 64'd1000);
    wait_result("j210", 64'd24);
    check_eq("j210_ndvd", PW'(n_dvd), PW'(N_210));

    // exponent zero
    n_dvd = 0;
    start_job("jexp0", 64'd1234, 64'd0, 64'd13);
    wait_result("jexp0", 64'd1);
    check_eq("jexp0_ndvd", PW'(n_dvd), PW'(N_EXP0));

    // moduli below two never touch the modulo unit
    n_dvd = 0; dvd_seen = 0;
    start_job("jm1", 64'd5, 64'd3, 64'd1);
    wait_result("jm1", 64'd0);
    start_job("jm0", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFF, 64'd0);
    wait_result("jm0", 64'd0);
    check_eq("jm_ndvd", PW'(n_dvd), '0);
    check_eq("jm_dvd_seen", PW'(dvd_seen), '0);

    // Delayed divisor ready, random remainder stalls, then result backpressure
    stall_mode = 1; res_tready = 1'b0;
    start_job("jst", 64'd3, 64'd5, 64'd7);
    wait_result("jst", 64'd5);
    stall_mode = 0;
    in_base_tdata = 64'd9; in_exp_tdata = 64'd9; in_mod_tdata = 64'd0; in_tvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check_eq("bp_rvalid", res_tvalid, 1'b1);
      check_eq("bp_rdata", PW'(res_tdata), PW'(64'd5));
      check_eq("bp_in_tready", in_tready, 1'b0);
      @(negedge clk);
    end
    res_tready = 1'b1;
    @(negedge clk);
    check_eq("bp_rel_tready", in_tready, 1'b1);
    check_eq("bp_rel_busy", busy, 1'b0);
    check_eq("bp_rel_rvalid", res_tvalid, 1'b0);
    @(negedge clk);
    in_tvalid = 1'b0;
    check_eq("bp2_busy", busy, 1'b1);
    check_eq("bp2_in_tready", in_tready, 1'b0);
    wait_result("bp2", 64'd0);

    // Reset while waiting on a remainder, then a fresh job
    start_job("jrst", 64'd3, 64'd5, 64'd7);
    for (int k = 0; k < 300 && !md_rem_tready; k++) @(negedge clk);
    check_eq("rst_wait_rem", md_rem_tready, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("mid");
    rst = 1'b0;
    @(negedge clk);
    n_dvd = 0;
    start_job("jpost", 64'd3, 64'd5, 64'd7);
    wait_result("jpost", 64'd5);
    check_eq("jpost_ndvd", PW'(n_dvd), PW'(N_35));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
